// File: rtl/alu_pipe.sv
// Two-stage pipelined ALU with valid/ready handshakes on both sides.
// S1 holds the accepted operation, S2 holds the computed result and carry.
// Also keeps a wrapping count of completed output transfers.
module alu_pipe #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_ctrl,
    input  logic [WIDTH-1:0] in_x,
    input  logic [WIDTH-1:0] in_y,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_carry,
    output logic [CNT_W-1:0] op_count
);

    // Stage 1: accepted opcode and operands
    logic             s1_v_reg;
    logic [3:0]       s1_ctrl_reg;
    logic [WIDTH-1:0] s1_x_reg;
    logic [WIDTH-1:0] s1_y_reg;

    // Stage 2: registered result
    logic             s2_v_reg;
    logic [WIDTH-1:0] s2_data_reg;
    logic             s2_carry_reg;

    logic [CNT_W-1:0] count_reg;

    // Combinational result of the operation sitting in S1
    logic [WIDTH-1:0] result_next;
    logic             carry_next;

    // Handshake terms
    logic s2_adv;
    logic accept;
    logic move;
    logic fire;

    assign s2_adv   = !s2_v_reg | out_ready;
    assign in_ready = !s1_v_reg | s2_adv;
    assign accept   = in_valid & in_ready;
    assign move     = s1_v_reg & s2_adv;
    assign fire     = s2_v_reg & out_ready;

    assign out_valid = s2_v_reg;
    assign out_data  = s2_data_reg;
    assign out_carry = s2_carry_reg;
    assign op_count  = count_reg;

    // Rotations by one place, built bit by bit so any WIDTH works
    logic [WIDTH-1:0] rotl_bits;
    logic [WIDTH-1:0] rotr_bits;

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_rot
            assign rotl_bits[gi] = s1_x_reg[(gi + WIDTH - 1) % WIDTH];
            assign rotr_bits[gi] = s1_x_reg[(gi + 1) % WIDTH];
        end
    endgenerate

    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] diff;

    assign sum  = s1_x_reg + s1_y_reg;
    assign diff = s1_x_reg - s1_y_reg;

    // Opcode decode; carry is signed overflow for add/sub and zero otherwise
    always_comb begin
        result_next = '0;
        carry_next  = 1'b0;
        case (s1_ctrl_reg)
            4'b0000: begin
                result_next = sum;
                carry_next  = (s1_x_reg[WIDTH-1] == s1_y_reg[WIDTH-1]) &&
                              (sum[WIDTH-1] != s1_x_reg[WIDTH-1]);
            end
            4'b0001: begin
                result_next = diff;
                carry_next  = (s1_x_reg[WIDTH-1] != s1_y_reg[WIDTH-1]) &&
                              (diff[WIDTH-1] != s1_x_reg[WIDTH-1]);
            end
            4'b0010: result_next = s1_x_reg & s1_y_reg;
            4'b0011: result_next = s1_x_reg | s1_y_reg;
            4'b0100: result_next = ~s1_x_reg;
            // Labelled "xnor" in older documentation, but the function is xor
            4'b0101: result_next = s1_x_reg ^ s1_y_reg;
            4'b0110: result_next = ~(s1_x_reg | s1_y_reg);
            4'b0111: result_next = {s1_y_reg[WIDTH-2:0], 1'b0};
            4'b1000: result_next = {1'b0, s1_y_reg[WIDTH-1:1]};
            4'b1001: result_next = {s1_x_reg[WIDTH-1], s1_x_reg[WIDTH-1:1]};
            4'b1010: result_next = rotl_bits;
            4'b1011: result_next = rotr_bits;
            4'b1100: result_next = {{(WIDTH-1){1'b0}}, (s1_x_reg == s1_y_reg)};
            default: begin
                result_next = '0;
                carry_next  = 1'b0;
            end
        endcase
    end

    // S1: load on input transfer, empty when its item moves on with nothing new arriving
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_v_reg    <= 1'b0;
            s1_ctrl_reg <= '0;
            s1_x_reg    <= '0;
            s1_y_reg    <= '0;
        end else if (accept) begin
            s1_v_reg    <= 1'b1;
            s1_ctrl_reg <= in_ctrl;
            s1_x_reg    <= in_x;
            s1_y_reg    <= in_y;
        end else if (move) begin
            s1_v_reg    <= 1'b0;
        end
    end

    // S2: payload only changes when S1 moves in, so it is frozen while stalled
    always_ff @(posedge clk) begin
        if (rst) begin
            s2_v_reg     <= 1'b0;
            s2_data_reg  <= '0;
            s2_carry_reg <= 1'b0;
        end else if (move) begin
            s2_v_reg     <= 1'b1;
            s2_data_reg  <= result_next;
            s2_carry_reg <= carry_next;
        end else if (fire) begin
            s2_v_reg     <= 1'b0;
        end
    end

    // Completed-transfer counter, wraps naturally at 2^CNT_W
    always_ff @(posedge clk) begin
        if (rst) begin
            count_reg <= '0;
        end else if (fire) begin
            count_reg <= count_reg + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_alu_pipe.sv
// Self-checking bench for alu_pipe: directed scenarios followed by a random
// streaming run, all checked against a queue-based reference model.
module tb_alu_pipe;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       in_valid;
    logic       out_ready;
    logic [3:0] in_ctrl;
    logic [7:0] in_x;
    logic [7:0] in_y;

    wire        in_ready;
    wire        out_valid;
    wire        out_carry;
    wire [7:0]  out_data;
    wire [15:0] op_count;

    wire        in_ready4;
    wire        out_valid4;
    wire        out_carry4;
    wire [7:0]  out_data4;
    wire [3:0]  op_count4;

    alu_pipe #(.WIDTH(8), .CNT_W(16)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_ctrl(in_ctrl), .in_x(in_x), .in_y(in_y),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_carry(out_carry),
        .op_count(op_count)
    );

    // Same stream into a narrow-counter instance to observe wrap-around
    alu_pipe #(.WIDTH(8), .CNT_W(4)) dut4 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready4),
        .in_ctrl(in_ctrl), .in_x(in_x), .in_y(in_y),
        .out_valid(out_valid4), .out_ready(out_ready),
        .out_data(out_data4), .out_carry(out_carry4),
        .op_count(op_count4)
    );

    int total = 0;
    int bad   = 0;

    logic [8:0]  exp_q [$];     // {carry, data} of accepted, not yet delivered ops
    int unsigned cnt_model;
    logic        stall_prev;
    logic [8:0]  stall_val;
    logic        last_acc;

    logic [8:0] sweep_exp [16] = '{9'h044, 9'h07E, 9'h061, 9'h0E3, 9'h09E, 9'h082,
                                   9'h01C, 9'h0C6, 9'h071, 9'h030, 9'h0C2, 9'h0B0,
                                   9'h000, 9'h000, 9'h000, 9'h000};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: opcode rules evaluated with ordinary integer arithmetic
    function automatic logic [8:0] ref_op(input logic [3:0] c, input logic [7:0] x, input logic [7:0] y);
        int ux, uy, sx, sy, r, res;
        logic cy;
        ux  = int'(x);
        uy  = int'(y);
        sx  = (ux >= 128) ? ux - 256 : ux;
        sy  = (uy >= 128) ? uy - 256 : uy;
        cy  = 1'b0;
        res = 0;
        case (int'(c))
            0:  begin r = sx + sy; cy = (r > 127) || (r < -128); res = r & 255; end
            1:  begin r = sx - sy; cy = (r > 127) || (r < -128); res = r & 255; end
            2:  res = ux & uy;
            3:  res = ux | uy;
            4:  res = 255 - ux;
            5:  res = ux ^ uy;
            6:  res = 255 - (ux | uy);
            7:  res = (uy * 2) % 256;
            8:  res = uy / 2;
            9:  res = ux / 2 + ((ux >= 128) ? 128 : 0);
            10: res = (ux * 2) % 256 + ux / 128;
            11: res = ux / 2 + (ux % 2) * 128;
            12: res = (ux == uy) ? 1 : 0;
            default: res = 0;
        endcase
        return {cy, res[7:0]};
    endfunction

    // One clock cycle: check outputs mid-cycle, update the model, advance past the edge
    task automatic step();
        logic acc;
        logic fire;
        @(negedge clk);
        acc = 1'b0;
        if (!rst) begin
            chk("in_ready", 32'(in_ready), 32'((exp_q.size() < 2) || out_ready));
            chk("in_ready4", 32'(in_ready4), 32'((exp_q.size() < 2) || out_ready));
            if (stall_prev) begin
                chk("stall_valid", 32'(out_valid), 32'(1));
                chk("stall_payload", 32'({out_carry, out_data}), 32'(stall_val));
            end
            if (out_valid) begin
                chk("valid_has_item", 32'(exp_q.size() > 0), 32'(1));
                if (exp_q.size() > 0)
                    chk("out_payload", 32'({out_carry, out_data}), 32'(exp_q[0]));
            end
            if (out_valid4) begin
                chk("valid4_has_item", 32'(exp_q.size() > 0), 32'(1));
                if (exp_q.size() > 0)
                    chk("out_payload4", 32'({out_carry4, out_data4}), 32'(exp_q[0]));
            end
            chk("op_count", 32'(op_count), cnt_model % 65536);
            chk("op_count4", 32'(op_count4), cnt_model % 16);
            acc        = in_valid && in_ready;
            fire       = out_valid && out_ready;
            stall_prev = out_valid && !out_ready;
            stall_val  = {out_carry, out_data};
            if (fire && exp_q.size() > 0) begin
                void'(exp_q.pop_front());
                cnt_model++;
            end
            if (acc)
                exp_q.push_back(ref_op(in_ctrl, in_x, in_y));
        end
        last_acc = acc;
        @(posedge clk);
        #1;
        if (rst) begin
            exp_q.delete();
            cnt_model  = 0;
            stall_prev = 1'b0;
        end
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        in_valid = 1'b0;
        step();
        rst      = 1'b0;
    endtask

    // Issue one op alone and check the literal result once it reaches S2
    task automatic single(input string tag, input logic [3:0] c, input logic [7:0] x,
                          input logic [7:0] y, input logic [8:0] expv);
        in_valid = 1'b1; in_ctrl = c; in_x = x; in_y = y;
        step();
        in_valid = 1'b0;
        step();
        chk(tag, 32'({out_valid, out_carry, out_data}), 32'({1'b1, expv}));
        step();
    endtask

    initial begin
        int accepted;
        int cyc;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        in_ctrl = '0; in_x = '0; in_y = '0;
        cnt_model = 0; stall_prev = 1'b0; stall_val = '0; last_acc = 1'b0;
        step();
        step();
        rst = 1'b0;

        // Reset values
        chk("rst_out_valid", 32'(out_valid), 32'(0));
        chk("rst_out_data", 32'(out_data), 32'(0));
        chk("rst_out_carry", 32'(out_carry), 32'(0));
        chk("rst_op_count", 32'(op_count), 32'(0));
        chk("rst_in_ready", 32'(in_ready), 32'(1));

        // Opcode sweep at full throughput, with latency checks on the first op
        out_ready = 1'b1;
        for (int c = 0; c < 16; c++) begin
            in_valid = 1'b1; in_ctrl = 4'(c); in_x = 8'h61; in_y = 8'hE3;
            step();
            chk("sweep_accept", 32'(last_acc), 32'(1));
            if (c == 0)
                chk("latency_not_yet", 32'(out_valid), 32'(0));
            else
                chk($sformatf("sweep_op%0d", c - 1), 32'({out_valid, out_carry, out_data}),
                    32'({1'b1, sweep_exp[c-1]}));
        end
        in_valid = 1'b0;
        step();
        chk("sweep_op15", 32'({out_valid, out_carry, out_data}), 32'({1'b1, sweep_exp[15]}));
        step();
        chk("sweep_count", 32'(op_count), 32'(16));
        chk("sweep_count4", 32'(op_count4), 32'(0));
        chk("sweep_drained", 32'(out_valid), 32'(0));

        // Overflow boundaries
        single("ovf_add", 4'b0000, 8'h7F, 8'h01, 9'h180);
        single("ovf_sub", 4'b0001, 8'h80, 8'h01, 9'h17F);
        single("add_wrap_nocarry", 4'b0000, 8'hFF, 8'h01, 9'h000);
        single("eq_true", 4'b1100, 8'h5A, 8'h5A, 9'h001);

        // Backpressure: two ops fill the pipe, the third waits at the source
        out_ready = 1'b0;
        in_valid = 1'b1; in_ctrl = 4'b0000; in_x = 8'h01; in_y = 8'h02;
        step();
        chk("bp_acc_a", 32'(last_acc), 32'(1));
        in_ctrl = 4'b0101; in_x = 8'h0F; in_y = 8'hF0;
        step();
        chk("bp_acc_b", 32'(last_acc), 32'(1));
        in_ctrl = 4'b0011; in_x = 8'h10; in_y = 8'h01;
        chk("bp_full_ready", 32'(in_ready), 32'(0));
        repeat (4) step();
        chk("bp_held_c", 32'(last_acc), 32'(0));
        chk("bp_hold_a", 32'({out_valid, out_data}), 32'({1'b1, 8'h03}));
        out_ready = 1'b1;
        step();
        chk("bp_acc_c", 32'(last_acc), 32'(1));
        chk("bp_out_b", 32'({out_valid, out_data}), 32'({1'b1, 8'hFF}));
        in_valid = 1'b0;
        step();
        chk("bp_out_c", 32'({out_valid, out_data}), 32'({1'b1, 8'h11}));
        step();
        chk("bp_drained", 32'(out_valid), 32'(0));

        // Reset with two ops in flight; an input in the reset cycle is dropped
        out_ready = 1'b0;
        in_valid = 1'b1; in_ctrl = 4'b0011; in_x = 8'hAA; in_y = 8'h01;
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0; in_valid = 1'b0;
        chk("midrst_out_valid", 32'(out_valid), 32'(0));
        chk("midrst_op_count", 32'(op_count), 32'(0));
        chk("midrst_in_ready", 32'(in_ready), 32'(1));
        out_ready = 1'b1;
        repeat (4) step();
        chk("midrst_no_output", 32'(op_count), 32'(0));

        // Counter wrap on the 4-bit instance: 17 nop transfers
        do_reset();
        out_ready = 1'b1;
        in_ctrl = 4'b1111; in_x = 8'h33; in_y = 8'h44;
        for (int i = 0; i < 17; i++) begin
            in_valid = 1'b1;
            step();
        end
        in_valid = 1'b0;
        repeat (3) step();
        chk("wrap_count4", 32'(op_count4), 32'(1));
        chk("wrap_count16", 32'(op_count), 32'(17));

        // Random streaming; the source holds an op until it is accepted
        accepted = 0;
        cyc = 0;
        in_valid = 1'b0;
        last_acc = 1'b0;
        while (accepted < 10000 && cyc < 60000) begin
            if (last_acc || !in_valid) begin
                in_valid = ($urandom_range(3) != 0);
                in_ctrl  = 4'($urandom_range(15));
                in_x     = 8'($urandom_range(255));
                in_y     = 8'($urandom_range(255));
            end
            out_ready = ($urandom_range(3) != 0);
            step();
            if (last_acc) accepted++;
            cyc++;
        end
        chk("random_budget", 32'(accepted), 32'(10000));
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (4) step();
        chk("random_drained", 32'(exp_q.size()), 32'(0));
        chk("random_count", 32'(op_count), cnt_model % 65536);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
